// File: rtl/regfile_pkg.sv
// Package: regfile_pkg
// Purpose: shared defaults, typedefs and bus-slicing helper for the multi-port
//          register file (regfile_mp) and its busy scoreboard.
// Contents:
//   DATA_W_DEF / DEPTH_DEF / ADDR_W_DEF - default geometry
//   addr_t / data_t                     - register address / data types at default geometry
//   rd_idx(p, w)                        - LSB position of port p in a flattened bus of w-bit lanes
package regfile_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 8;
  localparam int ADDR_W_DEF = $clog2(DEPTH_DEF);

  typedef logic [ADDR_W_DEF-1:0] addr_t;
  typedef logic [DATA_W_DEF-1:0] data_t;

  // Port p occupies bits [p*w +: w] of every flattened per-port bus.
  function automatic int rd_idx(input int p, input int w);
    return p * w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Module: regfile_scoreboard
// Purpose: busy-bit scoreboard. Decode reserves a destination register, any
//          write to that register releases it. A reserve and a release of the
//          same register on one edge leave it busy (the reserve belongs to a
//          newer producer). Register 0 is never busy.
// Ports:
//   clock    in  rising-edge clock
//   reset    in  asynchronous, active-high
//   rsv_en   in  reserve request
//   rsv_addr in  register to reserve
//   clr      in  per-register release (one bit per register written this edge)
//   busy     out registered busy vector, bit 0 always 0
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [DEPTH-1:0]  clr,
  output logic [DEPTH-1:0]  busy
);

  logic [DEPTH-1:0] set_s;
  logic [DEPTH-1:0] busy_nxt_s;
  logic [DEPTH-1:0] busy_r;

  // Decode the reserve request; register 0 can never be reserved.
  always_comb begin
    set_s = {DEPTH{1'b0}};
    for (int i = 1; i < DEPTH; i++) begin
      set_s[i] = rsv_en && (rsv_addr == ADDR_W'(i));
    end
  end

  // Release first, then reserve, so a same-edge reserve wins over the release.
  always_comb begin
    busy_nxt_s    = (busy_r & ~clr) | set_s;
    busy_nxt_s[0] = 1'b0;
  end

  // Busy vector register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_r <= {DEPTH{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign busy = busy_r;

endmodule

// File: rtl/regfile_mp.sv
// Module: regfile_mp
// Purpose: parametrised multi-port register file with registered reads,
//          hardwired-zero register 0 and a built-in busy scoreboard.
// Optional feature: define REGFILE_BYPASS_EN to forward a same-edge write to a
//          read of the same address (and mask rd_busy for it). Without it a
//          read returns the old contents. Register 0 is never forwarded.
// Ports:
//   clock, reset                 clock / async active-high reset
//   rd_en, rd_addr               per-port read request and address
//   rd_data, rd_valid            registered read data / valid (1-cycle latency)
//   rd_busy                      comb: read address is reserved and not being resolved
//   wr_en, wr_addr, wr_data      per-port write (highest port wins on collision)
//   rsv_en, rsv_addr             reserve a destination register
//   busy                         scoreboard vector
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  parameter  int NUM_RD = 2,
  parameter  int NUM_WR = 1,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [DEPTH-1:0]         busy
);

  logic [DATA_W-1:0] rf_r       [DEPTH];
  logic [ADDR_W-1:0] wa_s       [NUM_WR];
  logic [DATA_W-1:0] wd_s       [NUM_WR];
  logic [DEPTH-1:0]  wr_hit_s;
  logic [DATA_W-1:0] wr_val_s   [DEPTH];
  logic [ADDR_W-1:0] ra_s       [NUM_RD];
  logic [DATA_W-1:0] rd_next_s  [NUM_RD];
  logic [NUM_RD-1:0] byp_hit_s;
  logic [DATA_W-1:0] rd_data_r  [NUM_RD];
  logic [NUM_RD-1:0] rd_valid_r;
  logic [DEPTH-1:0]  busy_s;

  // Unflatten the write buses.
  always_comb begin
    for (int w = 0; w < NUM_WR; w++) begin
      wa_s[w] = wr_addr[rd_idx(w, ADDR_W) +: ADDR_W];
      wd_s[w] = wr_data[rd_idx(w, DATA_W) +: DATA_W];
    end
  end

  // Per-register write resolution; scanning ports upward lets the highest
  // matching port override. Register 0 never sees a hit.
  always_comb begin
    wr_hit_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      wr_val_s[i] = {DATA_W{1'b0}};
    end
    for (int i = 1; i < DEPTH; i++) begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (wa_s[w] == ADDR_W'(i))) begin
          wr_hit_s[i] = 1'b1;
          wr_val_s[i] = wd_s[w];
        end else begin
          wr_val_s[i] = wr_val_s[i];
        end
      end
    end
  end

  // Register storage; register 0 is reset to zero and never written.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        rf_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_hit_s[i]) begin
          rf_r[i] <= wr_val_s[i];
        end
      end
    end
  end

  // Read-side muxing, optional write forwarding and busy indication.
  always_comb begin
    rd_busy = {NUM_RD{1'b0}};
    for (int p = 0; p < NUM_RD; p++) begin
      ra_s[p] = rd_addr[rd_idx(p, ADDR_W) +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
      byp_hit_s[p] = wr_hit_s[ra_s[p]];
      rd_next_s[p] = byp_hit_s[p] ? wr_val_s[ra_s[p]] : rf_r[ra_s[p]];
`else
      byp_hit_s[p] = 1'b0;
      rd_next_s[p] = rf_r[ra_s[p]];
`endif
      rd_busy[p] = busy_s[ra_s[p]] && !byp_hit_s[p];
    end
  end

  // Read output registers; data holds when the port is idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_valid_r <= {NUM_RD{1'b0}};
      for (int p = 0; p < NUM_RD; p++) begin
        rd_data_r[p] <= {DATA_W{1'b0}};
      end
    end else begin
      rd_valid_r <= rd_en;
      for (int p = 0; p < NUM_RD; p++) begin
        if (rd_en[p]) begin
          rd_data_r[p] <= rd_next_s[p];
        end
      end
    end
  end

  // Flatten the registered read data.
  always_comb begin
    rd_data = {(NUM_RD*DATA_W){1'b0}};
    for (int p = 0; p < NUM_RD; p++) begin
      rd_data[rd_idx(p, DATA_W) +: DATA_W] = rd_data_r[p];
    end
  end

  assign rd_valid = rd_valid_r;
  assign busy     = busy_s;

  regfile_scoreboard #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clock    (clock),
    .reset    (reset),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .clr      (wr_hit_s),
    .busy     (busy_s)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp (DATA_W=8, DEPTH=8, NUM_RD=2, NUM_WR=2).
// Reference model: plain register/busy arrays updated from the behavioural rules.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int AW = 3;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic [1:0]  rd_en;
  logic [5:0]  rd_addr;
  logic [15:0] rd_data;
  logic [1:0]  rd_valid;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [5:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rsv_en;
  logic [2:0]  rsv_addr;
  logic [7:0]  busy;

  data_t      m_rf [8];
  logic [7:0] m_busy;
  data_t      e_rd [2];
  logic [1:0] e_valid;
  int checks = 0;
  int errors = 0;

  regfile_mp #(.DATA_W(8), .DEPTH(8), .NUM_RD(2), .NUM_WR(2)) dut (
    .clock(clock), .reset(reset),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Does any write port write nonzero register a this cycle?
  function automatic bit wr_hits(input addr_t a);
    bit h = 1'b0;
    for (int w = 0; w < 2; w++)
      if (wr_en[w] && wr_addr[w*AW +: AW] == a && a != 3'd0) h = 1'b1;
    return h;
  endfunction

  // Value written to a this cycle by the highest matching port.
  function automatic data_t wr_last(input addr_t a);
    data_t v = 8'h00;
    for (int w = 0; w < 2; w++)
      if (wr_en[w] && wr_addr[w*AW +: AW] == a) v = wr_data[w*8 +: 8];
    return v;
  endfunction

  function automatic logic [1:0] exp_rd_busy();
    logic [1:0] r;
    for (int p = 0; p < 2; p++) begin
      addr_t a = rd_addr[p*AW +: AW];
      r[p] = m_busy[a] && !(BYP && wr_hits(a));
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
    m_busy = 8'h00; e_rd[0] = 8'h00; e_rd[1] = 8'h00; e_valid = 2'b00;
  endtask

  task automatic idle();
    rd_en = 2'b00; rd_addr = 6'd0; wr_en = 2'b00; wr_addr = 6'd0; wr_data = 16'h0000;
    rsv_en = 1'b0; rsv_addr = 3'd0;
  endtask

  // Advance model and DUT one clock edge; leaves time at posedge + 1.
  task automatic tick();
    for (int p = 0; p < 2; p++) begin
      addr_t a = rd_addr[p*AW +: AW];
      if (rd_en[p]) e_rd[p] = (a == 3'd0) ? 8'h00 : ((BYP && wr_hits(a)) ? wr_last(a) : m_rf[a]);
    end
    e_valid = rd_en;
    for (int w = 0; w < 2; w++) begin
      addr_t a = wr_addr[w*AW +: AW];
      if (wr_en[w] && a != 3'd0) begin
        m_rf[a] = wr_data[w*8 +: 8];
        m_busy[a] = 1'b0;
      end
    end
    if (rsv_en && rsv_addr != 3'd0) m_busy[rsv_addr] = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle(); model_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++; if (busy !== 8'h00) begin errors++; $display("FAIL reset_busy got %h exp 00", busy); end
    checks++; if (rd_valid !== 2'b00) begin errors++; $display("FAIL reset_valid got %b exp 00", rd_valid); end
    checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL reset_data got %h exp 0000", rd_data); end
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      rd_en = 2'b11; rd_addr = {3'(7 - a), 3'(a)};
      tick();
      checks++; if (rd_valid !== 2'b11) begin errors++; $display("FAIL rdall_valid a=%0d got %b exp 11", a, rd_valid); end
      checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL rdall_data a=%0d got %h exp 0000", a, rd_data); end
    end
    idle();
  endtask

  task automatic test_write_read();
    wr_en = 2'b01; wr_addr = 6'd3; wr_data = 16'h00A5;
    tick();
    idle(); rd_en = 2'b01; rd_addr = 6'd3;
    tick();
    checks++; if (rd_data[7:0] !== 8'hA5 || rd_valid[0] !== 1'b1) begin
      errors++; $display("FAIL wr_rd_r3 got %h/%b exp a5/1", rd_data[7:0], rd_valid[0]); end
    idle();
    tick();
    checks++; if (rd_valid !== 2'b00 || rd_data[7:0] !== 8'hA5) begin
      errors++; $display("FAIL idle_hold got %h/%b exp a5/00", rd_data[7:0], rd_valid); end
  endtask

  task automatic test_reg0();
    wr_en = 2'b01; wr_addr = 6'd0; wr_data = 16'h00FF; rsv_en = 1'b1; rsv_addr = 3'd0;
    tick();
    idle(); rd_en = 2'b10; rd_addr = 6'o00;
    tick();
    checks++; if (rd_data[15:8] !== 8'h00) begin errors++; $display("FAIL r0_read got %h exp 00", rd_data[15:8]); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL r0_busy got %b exp 0", busy[0]); end
    idle();
  endtask

  task automatic test_rdw();
    wr_en = 2'b01; wr_addr = 6'd5; wr_data = 16'h0077;
    tick();
    wr_data = 16'h003C; rd_en = 2'b01; rd_addr = 6'd5;
    tick();
    checks++; if (rd_data[7:0] !== (BYP ? 8'h3C : 8'h77)) begin
      errors++; $display("FAIL rdw_r5 got %h exp %h", rd_data[7:0], BYP ? 8'h3C : 8'h77); end
    idle(); rd_en = 2'b01; rd_addr = 6'd5;
    tick();
    checks++; if (rd_data[7:0] !== 8'h3C) begin errors++; $display("FAIL rdw_after got %h exp 3c", rd_data[7:0]); end
    idle();
  endtask

  task automatic test_scoreboard();
    rsv_en = 1'b1; rsv_addr = 3'd2;
    tick();
    checks++; if (busy[2] !== 1'b1) begin errors++; $display("FAIL rsv_busy2 got %b exp 1", busy[2]); end
    idle(); rd_en = 2'b10; rd_addr = 6'o20; #1;
    checks++; if (rd_busy[1] !== 1'b1) begin errors++; $display("FAIL rd_busy2 got %b exp 1", rd_busy[1]); end
    wr_en = 2'b10; wr_addr = 6'o20; wr_data = 16'h5A00; #1;
    checks++; if (rd_busy[1] !== !BYP) begin errors++; $display("FAIL rd_busy2_wr got %b exp %b", rd_busy[1], !BYP); end
    tick();
    checks++; if (busy[2] !== 1'b0) begin errors++; $display("FAIL wr_clr2 got %b exp 0", busy[2]); end
    idle(); rsv_en = 1'b1; rsv_addr = 3'd2; wr_en = 2'b01; wr_addr = 6'd2; wr_data = 16'h0001;
    tick();
    checks++; if (busy[2] !== 1'b1) begin errors++; $display("FAIL rsv_wins got %b exp 1", busy[2]); end
    idle(); rsv_en = 1'b1; rsv_addr = 3'd2;
    tick();
    checks++; if (busy !== m_busy) begin errors++; $display("FAIL rsv_again got %h exp %h", busy, m_busy); end
    idle();
  endtask

  task automatic test_dual_write();
    wr_en = 2'b11; wr_addr = {3'd4, 3'd4}; wr_data = 16'h2211;
    tick();
    idle(); rd_en = 2'b11; rd_addr = {3'd4, 3'd4};
    tick();
    checks++; if (rd_data !== 16'h2222) begin errors++; $display("FAIL dual_wr_r4 got %h exp 2222", rd_data); end
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rd_en = 2'($urandom_range(0, 3)); rd_addr = 6'($urandom);
      wr_en = 2'($urandom_range(0, 3)); wr_addr = 6'($urandom); wr_data = 16'($urandom);
      rsv_en = ($urandom_range(0, 2) == 0); rsv_addr = 3'($urandom);
      #1;
      checks++; if (rd_busy !== exp_rd_busy()) begin
        errors++; $display("FAIL rnd_rd_busy n=%0d got %b exp %b", n, rd_busy, exp_rd_busy()); end
      tick();
      checks++; if (rd_valid !== e_valid) begin errors++; $display("FAIL rnd_valid n=%0d got %b exp %b", n, rd_valid, e_valid); end
      checks++; if (rd_data !== {e_rd[1], e_rd[0]}) begin
        errors++; $display("FAIL rnd_data n=%0d got %h exp %h", n, rd_data, {e_rd[1], e_rd[0]}); end
      checks++; if (busy !== m_busy) begin errors++; $display("FAIL rnd_busy n=%0d got %h exp %h", n, busy, m_busy); end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    rsv_en = 1'b1; rsv_addr = 3'd6; rd_en = 2'b11; rd_addr = {3'd3, 3'd4};
    tick();
    checks++; if (rd_valid !== 2'b11 || busy[6] !== 1'b1) begin
      errors++; $display("FAIL pre_reset got %b/%b exp 11/1", rd_valid, busy[6]); end
    rsv_en = 1'b0;
    #2; reset = 1'b1; #1;
    model_reset();
    checks++; if (rd_valid !== 2'b00) begin errors++; $display("FAIL mid_reset_valid got %b exp 00", rd_valid); end
    checks++; if (busy !== 8'h00) begin errors++; $display("FAIL mid_reset_busy got %h exp 00", busy); end
    @(posedge clock); #1; reset = 1'b0;
    rd_en = 2'b11; rd_addr = {3'd4, 3'd3};
    tick();
    checks++; if (rd_data !== 16'h0000 || rd_valid !== 2'b11) begin
      errors++; $display("FAIL post_reset_rd got %h/%b exp 0000/11", rd_data, rd_valid); end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_reg0();
    test_rdw();
    test_scoreboard();
    test_dual_write();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
